// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: register map, CTRL bit positions and mode/direction enums for pwm_multi.
package pwm_multi_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_CH_EN  = 4'd3;
    localparam logic [3:0] ADDR_CH_POL = 4'd4;
    localparam logic [3:0] ADDR_COUNT  = 4'd5;
    localparam logic [3:0] ADDR_DUTY0  = 4'd8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic {MODE_EDGE, MODE_CENTER} pwm_mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

endpackage

// File: rtl/pwm_multi_timebase.sv
// pwm_multi_timebase: shared PWM counter with up/down direction state and period-end pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : run enable; when low the counter idles at 0 counting up
//   mode_i     : 0 edge-aligned, 1 center-aligned
//   period_i   : active period P
//   cnt_o      : current count (never exceeds P)
//   dir_o      : 0 up, 1 down
//   co_o       : high on the last cycle of each period while enabled
module pwm_multi_timebase
    import pwm_multi_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          mode_i,
    input  logic [CW-1:0] period_i,
    output logic [CW-1:0] cnt_o,
    output logic          dir_o,
    output logic          co_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    pwm_dir_e      dir_q, dir_d;
    pwm_mode_e     mode;
    logic          at_top, p_small;

    assign mode    = pwm_mode_e'(mode_i);
    assign at_top  = cnt_q == period_i;
    assign p_small = period_i <= CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Edge mode always leaves dir up, which is what forces a down-counting
    // center sequence back to up one cycle after switching to edge mode.
    always_comb begin
        cnt_d = '0;
        dir_d = DIR_UP;
        if (en_i) begin
            if (mode == MODE_EDGE) begin
                cnt_d = at_top ? '0 : cnt_q + CW'(1);
            end else if (dir_q == DIR_UP) begin
                if (!at_top) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!p_small) begin
                    cnt_d = period_i - CW'(1);
                    dir_d = DIR_DOWN;
                end
            end else if (cnt_q > CW'(1)) begin
                cnt_d = cnt_q - CW'(1);
                dir_d = DIR_DOWN;
            end
        end
    end

    // Center periods end on the down-count 1, except P<=1 which never turns around.
    assign co_o  = en_i && ((mode == MODE_EDGE) ? at_top :
                            (dir_q == DIR_DOWN) ? cnt_q == CW'(1) : at_top && p_small);
    assign cnt_o = cnt_q;
    assign dir_o = dir_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared timebase, shadowed period/duty and period-end interrupt.
//   clk, rst_n : clock, asynchronous active-low reset
//   addr       : register word address
//   write      : single-cycle write strobe
//   wrdata     : write data
//   rddata     : registered read data (1-cycle latency)
//   pwm        : registered channel outputs
//   co         : period-end pulse
//   irq        : pending flag masked by irq_en
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     addr,
    input  logic           write,
    input  logic [31:0]    wrdata,
    output logic [31:0]    rddata,
    output logic [NCH-1:0] pwm,
    output logic           co,
    output logic           irq
);

    logic [2:0]     ctrl_q, ctrl_d;
    logic [CW-1:0]  per_sh_q, per_sh_d, per_q, per_d;
    logic [CW-1:0]  dsh_q [NCH];
    logic [CW-1:0]  dsh_d [NCH];
    logic [CW-1:0]  duty_q [NCH];
    logic [CW-1:0]  duty_d [NCH];
    logic [NCH-1:0] chen_q, chen_d, pol_q, pol_d, pwm_q, pwm_d;
    logic           pend_q, pend_d;
    logic [31:0]    rd_q, rd_d;
    logic [CW-1:0]  cnt;
    logic           dir_unused;
    logic           load;
    logic           unused_bits;

    // Direction and the upper write-data bits have no consumer at this level.
    assign unused_bits = ^{wrdata, dir_unused};

    pwm_multi_timebase #(.CW(CW)) u_tb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (ctrl_q[CTRL_EN]),
        .mode_i   (ctrl_q[CTRL_MODE]),
        .period_i (per_q),
        .cnt_o    (cnt),
        .dir_o    (dir_unused),
        .co_o     (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            per_sh_q <= '0;
            per_q    <= '0;
            chen_q   <= '0;
            pol_q    <= '0;
            pwm_q    <= '0;
            pend_q   <= 1'b0;
            rd_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                dsh_q[i]  <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            ctrl_q   <= ctrl_d;
            per_sh_q <= per_sh_d;
            per_q    <= per_d;
            chen_q   <= chen_d;
            pol_q    <= pol_d;
            pwm_q    <= pwm_d;
            pend_q   <= pend_d;
            rd_q     <= rd_d;
            dsh_q    <= dsh_d;
            duty_q   <= duty_d;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        per_sh_d = per_sh_q;
        chen_d   = chen_q;
        pol_d    = pol_q;
        dsh_d    = dsh_q;
        if (write && addr == ADDR_CTRL)   ctrl_d   = wrdata[2:0];
        if (write && addr == ADDR_PERIOD) per_sh_d = wrdata[CW-1:0];
        if (write && addr == ADDR_CH_EN)  chen_d   = wrdata[NCH-1:0];
        if (write && addr == ADDR_CH_POL) pol_d    = wrdata[NCH-1:0];
        for (int i = 0; i < NCH; i++)
            if (write && addr == ADDR_DUTY0 + 4'(i)) dsh_d[i] = wrdata[CW-1:0];
    end

    // Set on co wins over a simultaneous write-1-clear.
    assign pend_d = co | (pend_q & ~(write && addr == ADDR_STATUS && wrdata[0]));

    // Shadows go live at each period end and continuously while stopped, so
    // a write landing on a co cycle waits in the shadow for the next boundary.
    assign load = co | ~ctrl_q[CTRL_EN];

    always_comb begin
        per_d = load ? per_sh_q : per_q;
        pwm_d = pol_q;
        for (int i = 0; i < NCH; i++) begin
            duty_d[i] = load ? dsh_q[i] : duty_q[i];
            pwm_d[i]  = (ctrl_q[CTRL_EN] && chen_q[i]) ? (cnt < duty_q[i]) ^ pol_q[i] : pol_q[i];
        end
    end

    always_comb begin
        rd_d = '0;
        if (addr == ADDR_CTRL)   rd_d = 32'(ctrl_q);
        if (addr == ADDR_PERIOD) rd_d = 32'(per_sh_q);
        if (addr == ADDR_STATUS) rd_d = 32'(pend_q);
        if (addr == ADDR_CH_EN)  rd_d = 32'(chen_q);
        if (addr == ADDR_CH_POL) rd_d = 32'(pol_q);
        if (addr == ADDR_COUNT)  rd_d = 32'(cnt);
        for (int i = 0; i < NCH; i++)
            if (addr == ADDR_DUTY0 + 4'(i)) rd_d = 32'(dsh_q[i]);
    end

    assign rddata = rd_q;
    assign pwm    = pwm_q;
    assign irq    = pend_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed and randomized checks of pwm_multi against a period-position reference model.
module tb_pwm_multi;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     addr = 4'd5;
    logic           write = 1'b0;
    logic [31:0]    wrdata = '0;
    logic [31:0]    rddata;
    logic [NCH-1:0] pwm;
    logic           co, irq;

    int checks = 0;
    int failures = 0;

    pwm_multi #(.NCH(NCH), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .write  (write),
        .wrdata (wrdata),
        .rddata (rddata),
        .pwm    (pwm),
        .co     (co),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the counter is a position k within the current period;
    // the count value is derived from k and the mode.
    bit             m_en, m_mode, m_ie, m_pend;
    bit [NCH-1:0]   m_chen, m_pol;
    int             m_psh, m_p, k;
    int             m_dsh [NCH];
    int             m_d [NCH];
    logic [NCH-1:0] m_pwm;
    logic [31:0]    m_rd;

    function automatic int mlen();
        return m_mode ? (m_p == 0 ? 1 : 2 * m_p) : m_p + 1;
    endfunction

    function automatic int mcnt();
        return (m_mode && k > m_p) ? 2 * m_p - k : k;
    endfunction

    function automatic bit mco();
        return m_en && (k == mlen() - 1);
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] a);
        int ai;
        ai = int'(a);
        case (ai)
            0: return {29'd0, m_ie, m_mode, m_en};
            1: return 32'(m_psh);
            2: return {31'd0, m_pend};
            3: return 32'(m_chen);
            4: return 32'(m_pol);
            5: return 32'(mcnt());
            default: return (ai >= 8 && ai < 8 + NCH) ? 32'(m_dsh[ai-8]) : 32'd0;
        endcase
    endfunction

    task automatic mreset();
        m_en = 0; m_mode = 0; m_ie = 0; m_pend = 0;
        m_chen = '0; m_pol = '0; m_psh = 0; m_p = 0; k = 0;
        for (int i = 0; i < NCH; i++) begin
            m_dsh[i] = 0;
            m_d[i] = 0;
        end
        m_pwm = '0;
        m_rd = '0;
    endtask

    task automatic mstep();
        bit co_n, mode_o;
        int c, ai;
        co_n = mco();
        mode_o = m_mode;
        c = mcnt();
        for (int i = 0; i < NCH; i++)
            m_pwm[i] = (m_en && m_chen[i]) ? ((c < m_d[i]) ^ m_pol[i]) : m_pol[i];
        m_rd = mread(addr);
        k = m_en ? (k + 1) % mlen() : 0;
        c = mcnt();
        if (co_n || !m_en) begin
            m_p = m_psh;
            m_d = m_dsh;
        end
        if (co_n) m_pend = 1;
        else if (write && addr == 4'd2 && wrdata[0]) m_pend = 0;
        if (write) begin
            ai = int'(addr);
            if (ai == 0) {m_ie, m_mode, m_en} = wrdata[2:0];
            if (ai == 1) m_psh = int'(wrdata[CW-1:0]);
            if (ai == 3) m_chen = wrdata[NCH-1:0];
            if (ai == 4) m_pol = wrdata[NCH-1:0];
            if (ai >= 8 && ai < 8 + NCH) m_dsh[ai-8] = int'(wrdata[CW-1:0]);
        end
        // A mode switch keeps the count value and restarts the new mode counting up from it.
        if (m_mode != mode_o) k = c;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("rddata", rddata, m_rd);
        chk("pwm", 32'(pwm), 32'(m_pwm));
        chk("co", 32'(co), 32'(mco()));
        chk("irq", 32'(irq), 32'(m_pend & m_ie));
    end

    int hi [NCH];
    int nco;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a;
        write = 1'b1;
        wrdata = d;
        step();
        write = 1'b0;
        addr = 4'd5;
    endtask

    task automatic wait_co();
        int n;
        n = 0;
        while (!co && n < 300) begin
            step();
            n++;
        end
        chk("wait_co_timeout", 32'(co), 32'd1);
    endtask

    task automatic measure(input int n);
        nco = 0;
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        repeat (n) begin
            for (int i = 0; i < NCH; i++) hi[i] += int'(pwm[i]);
            nco += int'(co);
            step();
        end
    endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rd;
        step(2);
        chk("reset_rddata", rddata, 32'd0);
        chk("reset_pwm", 32'(pwm), 32'd0);
        chk("reset_co", 32'(co), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        step(2);

        wr(4'd1, 9); wr(4'd8, 3); wr(4'd9, 0); wr(4'd10, 10);
        wr(4'd3, 'hF); wr(4'd4, 0); wr(4'd0, 1);
        wait_co(); step();
        measure(10);
        chk("edge_pwm0_high", hi[0], 3);
        chk("edge_pwm1_high", hi[1], 0);
        chk("edge_pwm2_high", hi[2], 10);
        chk("edge_co_per_10", nco, 1);

        step(3);
        wr(4'd8, 7);
        wait_co(); step();
        measure(10);
        chk("shadow_mid_period", hi[0], 7);
        wait_co();
        wr(4'd8, 2);
        measure(10);
        chk("shadow_on_co_old", hi[0], 7);
        measure(10);
        chk("shadow_on_co_new", hi[0], 2);

        wr(4'd0, 0); wr(4'd1, 4); wr(4'd8, 2); wr(4'd0, 3);
        wait_co(); step();
        measure(8);
        chk("center_pwm0_high", hi[0], 3);
        chk("center_co_per_8", nco, 1);
        measure(16);
        chk("center_co_per_16", nco, 2);

        wr(4'd1, 9); wr(4'd0, 1); wr(4'd4, 2); wr(4'd3, 1);
        step(12);
        measure(10);
        chk("pol_pwm0_high", hi[0], 2);
        chk("pol_pwm1_high", hi[1], 10);
        chk("pol_pwm2_high", hi[2], 0);
        wr(4'd0, 0);
        step(2);
        chk("disabled_pwm", 32'(pwm), 32'h2);
        chk("disabled_co", 32'(co), 32'd0);
        chk("disabled_count", rddata, 32'd0);

        wr(4'd2, 1);
        chk("irq_cleared", 32'(irq), 32'd0);
        wr(4'd0, 5);
        chk("irq_before_co", 32'(irq), 32'd0);
        wait_co();
        chk("irq_on_co_cycle", 32'(irq), 32'd0);
        step();
        chk("irq_after_co", 32'(irq), 32'd1);
        wait_co();
        wr(4'd2, 1);
        chk("irq_set_wins", 32'(irq), 32'd1);
        wr(4'd2, 1);
        chk("irq_clear", 32'(irq), 32'd0);
        wait_co(); step();
        wr(4'd0, 1);
        chk("irq_masked", 32'(irq), 32'd0);
        wr(4'd0, 5);
        chk("irq_unmasked", 32'(irq), 32'd1);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                addr = 4'($urandom_range(0, 15));
                step();
            end else begin
                ra = 4'($urandom_range(0, 15));
                if (ra == 4'd0)
                    rd = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
                else if (ra == 4'd1)
                    rd = 32'($urandom_range(0, 12));
                else if (ra >= 4'd8)
                    rd = 32'($urandom_range(0, 14));
                else
                    rd = $urandom;
                wr(ra, rd);
            end
        end

        wr(4'd1, 9); wr(4'd3, 'hF); wr(4'd4, 'h8); wr(4'd8, 5); wr(4'd0, 5);
        step(4);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm), 32'd0);
        chk("async_rst_co", 32'(co), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_rddata", rddata, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int a = 0; a < 8 + NCH; a++) begin
            addr = 4'(a);
            step();
            chk("post_reset_read", rddata, 32'd0);
        end
        addr = 4'd5;
        step(5);
        chk("post_reset_count", rddata, 32'd0);
        chk("post_reset_co", 32'(co), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM peripheral with a shared timebase and one register-mapped slave port.
- Successor to the single-channel period/duty PWM peripheral, extended with:
  - NCH channels
  - parametrised counter width
  - edge- or center-aligned mode
  - shadowed (glitch-free) period/duty updates
  - per-channel enable and polarity
  - period-end interrupt
- Sits on the processor's simple memory-mapped bus next to the other timer peripherals.

Parameters:
- NCH, 4, number of PWM channels, legal range 1..8.
- CW, 16, counter / period / duty width in bits, legal range 2..32.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  4  word address of register.
- write  input  1  write strobe; single cycle per write.
- wrdata  input  32  write data; period/duty use bits [CW-1:0].
- rddata  output  32  registered read data for addr.
- pwm  output  NCH  registered PWM outputs.
- co  output  1  one-cycle pulse on the last cycle of each PWM period (enabled only).
- irq  output  1  level interrupt, equal to status flag AND irq_en.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). Asserting rst_n low clears every register, the counter and the direction bit (dir=up), and forces pwm=0, co=0, irq=0, rddata=0, including mid-period.
- Register map (word address):
  - 0 CTRL: bit0 en, bit1 mode (0 edge, 1 center), bit2 irq_en.
  - 1 PERIOD: shadow.
  - 2 STATUS: bit0 pend; write 1 clears it.
  - 3 CH_EN: bits [NCH-1:0].
  - 4 CH_POL: bits [NCH-1:0].
  - 5 COUNT: read-only.
  - 8+i DUTY[i]: shadow, i < NCH.
  - Writes to unmapped or read-only addresses are ignored; reads of them return 0.
- Read: rddata <= value(addr) every cycle, so it has 1-cycle latency. PERIOD and DUTY reads return the shadow values. Unused upper bits read 0.
- CTRL, CH_EN and CH_POL take effect the cycle after the write.
- Shadowing:
  - PERIOD and DUTY writes go to shadow registers.
  - Shadows are copied to the active registers on any cycle where co=1, and on every cycle while en=0.
  - A write coinciding with co: the new value lands in the shadow only and becomes active at the next boundary.
- Counter, en=0: cnt held at 0, dir=up.
- Counter, edge mode (P = active period):
  - cnt 0..P, then wraps to 0.
  - co = (cnt==P). Period length is P+1.
- Counter, center mode:
  - In up: if cnt<P, cnt++. At cnt==P: if P>1, cnt=P-1 and dir=down; else cnt=0.
  - In down: if cnt==1, cnt=0 and dir=up; else cnt--.
  - co = (dir==down && cnt==1) || (dir==up && cnt==P && P<=1).
  - Period length is 2P for P>=1, and 1 for P=0.
- Mode change while en=1: takes effect immediately. If dir was down and the new mode is edge, dir is forced up on the next cycle.
- Channel output:
  - raw_i = (cnt < D_i), where D_i is the active duty.
  - pwm_i is registered from raw_i, so it lags cnt by 1 cycle.
  - pwm_i <= (en && CH_EN_i) ? raw_i ^ POL_i : POL_i.
- Duty semantics:
  - Edge mode: high cycles per period = min(D, P+1).
  - Center mode: D=0 gives 0 high cycles; 1<=D<=P gives 2D-1; D>P gives 2P.
  - D=0 gives constant idle level. D > P gives constant active level.
- Width: compares are unsigned CW-bit. Wrap is impossible because cnt never exceeds P.
- Interrupt:
  - pend is set on co.
  - A STATUS write-1-clear in the same cycle as co leaves pend set (set wins).
  - Clearing irq_en masks irq without clearing pend.

Decomposition:
- Package pwm_multi_pkg contains:
  - register address constants (ADDR_CTRL … ADDR_DUTY0);
  - CTRL bit indices;
  - enum pwm_mode_e {MODE_EDGE, MODE_CENTER}.
- Sub-module pwm_multi_timebase (clk, rst_n, en, mode, period → cnt, dir, co) holds the counter and direction FSM. The top level holds registers, shadowing, channel compare and interrupt.

Test Plan:
- Edge mode, NCH=4, CW=16: PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, CH_EN=0xF, POL=0, en=1 → co every 10 cycles; pwm0 high 3 of 10; pwm1 always 0; pwm2 always 1.
- Center mode, PERIOD=4, DUTY0=2 → period 8 cycles; cnt sequence 0,1,2,3,4,3,2,1; pwm0 high 3 consecutive cycles; co when cnt==1 in down.
- Shadowing: write DUTY0=7 mid-period (edge, P=9) → pwm0 keeps 3-cycle width until co, then 7. Write coinciding with co → new value active only after the following co.
- Polarity/enable: POL=0x2, CH_EN=0x1 → pwm1 constant 1, pwm0 toggles. en=0 → pwm=POL pattern, COUNT reads 0, co=0.
- Interrupt: irq_en=1 → irq rises 1 cycle after co. STATUS write 1 on a co cycle → pend stays 1. Write 1 on a non-co cycle → irq 0 next cycle.
- Async reset mid-period: rst_n low between clk edges → pwm, co, irq go 0 immediately; after release, all registers read 0 and the counter stays idle.
